// File: rtl/rf_write_port_arbiter.sv
// Owns the register file write port and shares it between writeback, the mul/div unit and debug.
// After reset it clears all 32 registers before the pipeline is released.
module rf_write_port_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter logic [31:0] CLEAR_VALUE  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        wb_we,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    input  logic        mdu_valid,
    input  logic [4:0]  mdu_rd,
    input  logic [31:0] mdu_data,
    output logic        mdu_ready,
    input  logic        dbg_req,
    input  logic [4:0]  dbg_addr,
    input  logic [31:0] dbg_data,
    output logic        dbg_ack,
    output logic [4:0]  rf_A3,
    output logic [31:0] rf_WD3,
    output logic        rf_WE3,
    output logic        pipe_stall,
    output logic        init_done
);

    typedef enum logic {CLEAR, RUN} state_t;
    typedef enum logic [1:0] {GNT_NONE, GNT_WB, GNT_MDU, GNT_DBG} grant_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t     state_q, state_d;
    logic [4:0] clr_idx_q, clr_idx_d;
    logic [3:0] mdu_wait_q, mdu_wait_d;
    logic [3:0] dbg_wait_q, dbg_wait_d;
    grant_t     grant;
    logic       forced;
    logic       wb_valid;

    assign wb_valid = wb_we && (wb_rd != 5'd0);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= CLEAR;
            clr_idx_q  <= 5'd0;
            mdu_wait_q <= 4'd0;
            dbg_wait_q <= 4'd0;
        end else begin
            state_q    <= state_d;
            clr_idx_q  <= clr_idx_d;
            mdu_wait_q <= mdu_wait_d;
            dbg_wait_q <= dbg_wait_d;
        end
    end

    // A starved MDU or debug request outranks writeback and freezes the pipeline for that cycle.
    always_comb begin
        grant  = GNT_NONE;
        forced = 1'b0;
        if (state_q == RUN) begin
            if (mdu_valid && (mdu_wait_q == LIMIT)) begin
                grant  = GNT_MDU;
                forced = 1'b1;
            end else if (dbg_req && (dbg_wait_q == LIMIT)) begin
                grant  = GNT_DBG;
                forced = 1'b1;
            end else if (wb_valid) begin
                grant = GNT_WB;
            end else if (mdu_valid) begin
                grant = GNT_MDU;
            end else if (dbg_req) begin
                grant = GNT_DBG;
            end
        end
    end

    always_comb begin
        rf_WE3     = 1'b0;
        rf_A3      = 5'd0;
        rf_WD3     = 32'd0;
        mdu_ready  = 1'b0;
        dbg_ack    = 1'b0;
        pipe_stall = 1'b1;
        init_done  = 1'b0;
        if (resetn) begin
            if (state_q == CLEAR) begin
                rf_WE3 = 1'b1;
                rf_A3  = clr_idx_q;
                rf_WD3 = CLEAR_VALUE;
            end else begin
                init_done  = 1'b1;
                pipe_stall = forced && wb_valid;
                case (grant)
                    GNT_WB: begin
                        rf_WE3 = 1'b1;
                        rf_A3  = wb_rd;
                        rf_WD3 = wb_data;
                    end
                    GNT_MDU: begin
                        mdu_ready = 1'b1;
                        if (mdu_rd != 5'd0) begin
                            rf_WE3 = 1'b1;
                            rf_A3  = mdu_rd;
                            rf_WD3 = mdu_data;
                        end
                    end
                    GNT_DBG: begin
                        dbg_ack = 1'b1;
                        if (dbg_addr != 5'd0) begin
                            rf_WE3 = 1'b1;
                            rf_A3  = dbg_addr;
                            rf_WD3 = dbg_data;
                        end
                    end
                    default: begin
                        rf_WE3 = 1'b0;
                    end
                endcase
            end
        end
    end

    // Wait counters only run once the clear is finished; they saturate so a starved requester stays starved.
    always_comb begin
        state_d    = state_q;
        clr_idx_d  = clr_idx_q;
        mdu_wait_d = mdu_wait_q;
        dbg_wait_d = dbg_wait_q;
        if (state_q == CLEAR) begin
            clr_idx_d  = clr_idx_q + 5'd1;
            mdu_wait_d = 4'd0;
            dbg_wait_d = 4'd0;
            if (clr_idx_q == 5'd31) begin
                state_d = RUN;
            end
        end else begin
            if (!mdu_valid || (grant == GNT_MDU)) begin
                mdu_wait_d = 4'd0;
            end else if (mdu_wait_q != LIMIT) begin
                mdu_wait_d = mdu_wait_q + 4'd1;
            end
            if (!dbg_req || (grant == GNT_DBG)) begin
                dbg_wait_d = 4'd0;
            end else if (dbg_wait_q != LIMIT) begin
                dbg_wait_d = dbg_wait_q + 4'd1;
            end
        end
    end

endmodule
